// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with target buffer: combinational lookup in IF,
// resolved-branch update from EX, and saturating branch/mispredict statistics.
module branch_predictor_bht_entry #(
    parameter int PC_WIDTH = 32,
    parameter int TAG_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                wrSel,
    input  logic [TAG_BITS-1:0] updTag,
    input  logic                updTaken,
    input  logic [PC_WIDTH-1:0] updTarget,
    output logic                valid,
    output logic [TAG_BITS-1:0] tag,
    output logic [PC_WIDTH-1:0] target,
    output logic [1:0]          ctr
);
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic updHit;
    assign updHit = valid && (tag == updTag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid  <= 1'b0;
            ctr    <= WNT;
            tag    <= '0;
            target <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (wrSel) begin
            if (updHit) begin
                if (updTaken) begin
                    if (ctr != ST) ctr <= ctr + 2'd1;
                    target <= updTarget;
                end else if (ctr != SNT) begin
                    ctr <= ctr - 2'd1;
                end
            end else if (updTaken) begin
                // a taken miss evicts whatever lived at this index
                valid  <= 1'b1;
                tag    <= updTag;
                target <= updTarget;
                ctr    <= WT;
            end
        end
    end
endmodule

module branch_predictor_bht #(
    parameter int ENTRIES   = 64,
    parameter int PC_WIDTH  = 32,
    parameter int TAG_BITS  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic [PC_WIDTH-1:0]  upd_target,
    input  logic                 upd_pred_taken,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);
    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = TAG_LO + TAG_BITS - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [IDX_W-1:0]    lookIdx, updIdx;
    logic [TAG_BITS-1:0] lookTag, updTag;
    logic                updMiss;
    logic                unusedUpdPc;

    assign lookIdx     = lookup_pc[TAG_LO-1:2];
    assign lookTag     = lookup_pc[TAG_HI:TAG_LO];
    assign updIdx      = upd_pc[TAG_LO-1:2];
    assign updTag      = upd_pc[TAG_HI:TAG_LO];
    assign updMiss     = upd_pred_taken != upd_taken;
    assign unusedUpdPc = ^upd_pc;

    logic                entryValid  [ENTRIES];
    logic [TAG_BITS-1:0] entryTag    [ENTRIES];
    logic [PC_WIDTH-1:0] entryTarget [ENTRIES];
    logic [1:0]          entryCtr    [ENTRIES];

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : gEntry
            branch_predictor_bht_entry #(
                .PC_WIDTH(PC_WIDTH),
                .TAG_BITS(TAG_BITS)
            ) uEntry (
                .clk      (clk),
                .reset    (reset),
                .clear    (clear),
                .wrSel    (upd_valid && (updIdx == IDX_W'(i))),
                .updTag   (updTag),
                .updTaken (upd_taken),
                .updTarget(upd_target),
                .valid    (entryValid[i]),
                .tag      (entryTag[i]),
                .target   (entryTarget[i]),
                .ctr      (entryCtr[i])
            );
        end
    endgenerate

    // lookup reads the registered array, so a same-cycle update is not visible yet
    assign pred_hit    = entryValid[lookIdx] && (entryTag[lookIdx] == lookTag);
    assign pred_taken  = pred_hit && entryCtr[lookIdx][1];
    assign pred_target = pred_taken ? entryTarget[lookIdx] : lookup_pc + PC_WIDTH'(4);

    // statistics ignore clear: a dropped table update still counts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= upd_valid && updMiss;
            if (upd_valid) begin
                if (branch_count != CNT_MAX) branch_count <= branch_count + CNT_WIDTH'(1);
                if (updMiss && (mispredict_count != CNT_MAX))
                    mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: directed vector table, corner sequences and
// randomized traffic against an array-based reference model.
module tb_branch_predictor_bht;
    localparam int ENTRIES   = 16;
    localparam int PC_WIDTH  = 32;
    localparam int TAG_BITS  = 8;
    localparam int CNT_WIDTH = 4;
    localparam int CMAX      = 15;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 clear = 1'b0;
    logic [PC_WIDTH-1:0]  lookup_pc = '0;
    logic                 pred_hit, pred_taken;
    logic [PC_WIDTH-1:0]  pred_target;
    logic                 upd_valid = 1'b0;
    logic [PC_WIDTH-1:0]  upd_pc = '0;
    logic                 upd_taken = 1'b0;
    logic [PC_WIDTH-1:0]  upd_target = '0;
    logic                 upd_pred_taken = 1'b0;
    logic                 mispredict;
    logic [CNT_WIDTH-1:0] branch_count, mispredict_count;

    branch_predictor_bht #(
        .ENTRIES(ENTRIES), .PC_WIDTH(PC_WIDTH), .TAG_BITS(TAG_BITS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .mispredict(mispredict), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // reference model: per-index valid/tag/target and a 0..3 confidence level
    bit          mValid [ENTRIES];
    int          mTag   [ENTRIES];
    logic [31:0] mTarget[ENTRIES];
    int          mCtr   [ENTRIES];
    int          mBranch, mMisp;
    bit          mMispReg;

    function automatic int idxOf(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction
    function automatic int tagOf(logic [31:0] pc);
        return int'((pc / (4 * ENTRIES)) % 256);
    endfunction
    function automatic bit mHit(logic [31:0] pc);
        return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
    endfunction
    function automatic bit mTaken(logic [31:0] pc);
        return mHit(pc) && (mCtr[idxOf(pc)] >= 2);
    endfunction
    function automatic logic [31:0] mTgt(logic [31:0] pc);
        return mTaken(pc) ? mTarget[idxOf(pc)] : pc + 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0;
            mCtr[i]   = 1;
        end
        mBranch = 0; mMisp = 0; mMispReg = 1'b0;
    endtask

    task automatic modelEdge();
        int i;
        if (upd_valid) begin
            if (mBranch < CMAX) mBranch++;
            if (upd_pred_taken != upd_taken && mMisp < CMAX) mMisp++;
        end
        mMispReg = upd_valid && (upd_pred_taken != upd_taken);
        i = idxOf(upd_pc);
        if (clear) begin
            for (int k = 0; k < ENTRIES; k++) mValid[k] = 1'b0;
        end else if (upd_valid) begin
            if (mHit(upd_pc)) begin
                if (upd_taken) begin
                    if (mCtr[i] < 3) mCtr[i]++;
                    mTarget[i] = upd_target;
                end else if (mCtr[i] > 0) mCtr[i]--;
            end else if (upd_taken) begin
                mValid[i] = 1'b1; mTag[i] = tagOf(upd_pc);
                mTarget[i] = upd_target; mCtr[i] = 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkAll();
        chk("hit", {31'd0, pred_hit}, {31'd0, mHit(lookup_pc)});
        chk("taken", {31'd0, pred_taken}, {31'd0, mTaken(lookup_pc)});
        chk("target", pred_target, mTgt(lookup_pc));
        chk("mispredict", {31'd0, mispredict}, {31'd0, mMispReg});
        chk("branchCount", 32'(branch_count), 32'(mBranch));
        chk("mispredictCount", 32'(mispredict_count), 32'(mMisp));
    endtask

    task automatic drive(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utgt, input bit upt, input bit clr);
        lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; clear = clr;
    endtask

    // called just after a rising edge; checks before the next edge, then models it
    task automatic cycle(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                         input bit ut, input logic [31:0] utgt, input bit upt, input bit clr);
        drive(lpc, uv, upc, ut, utgt, upt, clr);
        @(negedge clk);
        checkAll();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        drive(32'h0040_0010, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    typedef struct {
        logic [31:0] lpc;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [31:0] utgt;
        bit          upt;
        bit          expHit;
        bit          expTaken;
        logic [31:0] expTgt;
        bit          expMisp;
    } vec_t;

    function automatic vec_t mk(logic [31:0] lpc, bit uv, logic [31:0] upc, bit ut,
                                logic [31:0] utgt, bit upt, bit eh, bit et,
                                logic [31:0] etgt, bit em);
        vec_t v;
        v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
        v.expHit = eh; v.expTaken = et; v.expTgt = etgt; v.expMisp = em;
        return v;
    endfunction

    vec_t tbl[13];
    logic [31:0] lastPc;

    initial begin
        tbl[0]  = mk(32'h0040_0010, 0, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0040_0014, 0);
        tbl[1]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0, 0, 32'h0040_0014, 0);
        tbl[2]  = mk(32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0,         0, 1, 1, 32'h0040_0040, 1);
        tbl[3]  = mk(32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0,         0, 1, 0, 32'h0040_0014, 0);
        tbl[4]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 1, 1, 0, 32'h0040_0014, 0);
        tbl[5]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 1, 1, 0, 32'h0040_0014, 0);
        tbl[6]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 1, 1, 1, 32'h0040_0040, 0);
        tbl[7]  = mk(32'h0040_0010, 0, 32'h0,         0, 32'h0,         0, 1, 1, 32'h0040_0040, 0);
        tbl[8]  = mk(32'h0040_0050, 1, 32'h0040_0050, 1, 32'h0040_0100, 0, 0, 0, 32'h0040_0054, 0);
        tbl[9]  = mk(32'h0040_0010, 0, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0040_0014, 1);
        tbl[10] = mk(32'h0040_0050, 1, 32'h0040_0090, 0, 32'h0,         0, 1, 1, 32'h0040_0100, 0);
        tbl[11] = mk(32'h0040_0050, 0, 32'h0,         0, 32'h0,         0, 1, 1, 32'h0040_0100, 0);
        tbl[12] = mk(32'h0040_0090, 0, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0040_0094, 0);

        // reset values seen asynchronously, before any edge
        modelReset();
        #2;
        chk("resetHit", {31'd0, pred_hit}, 32'd0);
        chk("resetBranchCount", 32'(branch_count), 32'd0);
        doReset();

        // directed table: training, counter walk, aliasing
        for (int v = 0; v < 13; v++) begin
            drive(tbl[v].lpc, tbl[v].uv, tbl[v].upc, tbl[v].ut, tbl[v].utgt, tbl[v].upt, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d hit", v), {31'd0, pred_hit}, {31'd0, tbl[v].expHit});
            chk($sformatf("tbl%0d taken", v), {31'd0, pred_taken}, {31'd0, tbl[v].expTaken});
            chk($sformatf("tbl%0d target", v), pred_target, tbl[v].expTgt);
            chk($sformatf("tbl%0d mispredict", v), {31'd0, mispredict}, {31'd0, tbl[v].expMisp});
            checkAll();
            @(posedge clk);
            modelEdge();
            #1;
        end
        chk("tblBranchCount", 32'(branch_count), 32'd8);
        chk("tblMispredictCount", 32'(mispredict_count), 32'd2);

        // same-cycle lookup/update collision from reset: old miss, then hit
        doReset();
        cycle(32'h0040_0020, 1, 32'h0040_0020, 1, 32'h0040_0200, 0, 0);
        chk("collNextHit", {31'd0, pred_hit}, 32'd1);
        chk("collNextTarget", pred_target, 32'h0040_0200);

        // clear beats a simultaneous update, but the update is still counted
        cycle(32'h0040_0030, 1, 32'h0040_0030, 1, 32'h0040_0300, 1, 1);
        chk("clrHitOld", {31'd0, pred_hit}, 32'd0);
        lookup_pc = 32'h0040_0030;
        #1;
        chk("clrHitNew", {31'd0, pred_hit}, 32'd0);
        chk("clrBranchCount", 32'(branch_count), 32'd2);

        // randomized traffic over a small PC pool to force hits and aliasing
        for (int n = 0; n < 400; n++) begin
            logic [31:0] lpc, upc;
            bit uv, ut, upt, clr;
            upc = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4;
            lpc = ($urandom_range(0, 3) == 0) ? upc
                                              : 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4;
            uv  = $urandom_range(0, 9) < 6;
            ut  = $urandom_range(0, 1) == 1;
            upt = ($urandom_range(0, 3) == 0) ? !mTaken(upc) : mTaken(upc);
            clr = $urandom_range(0, 39) == 0;
            cycle(lpc, uv, upc, ut, $urandom & 32'hFFFF_FFFC, upt, clr);
        end

        // saturation of both statistics counters
        doReset();
        lastPc = '0;
        for (int n = 0; n < 20; n++) begin
            lastPc = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4;
            cycle(lastPc, 1, lastPc, 1, 32'h0041_0000 + 32'(n) * 4, 0, 0);
        end
        chk("satBranchCount", 32'(branch_count), 32'd15);
        chk("satMispredictCount", 32'(mispredict_count), 32'd15);
        lookup_pc = lastPc;
        #1;
        chk("preResetHit", {31'd0, pred_hit}, 32'd1);
        chk("preResetMispredict", {31'd0, mispredict}, 32'd1);

        // asynchronous reset between edges
        reset = 1'b0;
        #1;
        chk("asyncHit", {31'd0, pred_hit}, 32'd0);
        chk("asyncTaken", {31'd0, pred_taken}, 32'd0);
        chk("asyncTarget", pred_target, lastPc + 32'd4);
        chk("asyncMispredict", {31'd0, mispredict}, 32'd0);
        chk("asyncBranchCount", 32'(branch_count), 32'd0);
        chk("asyncMispredictCount", 32'(mispredict_count), 32'd0);
        doReset();

        // first update after release is processed normally
        cycle(32'h0040_0044, 1, 32'h0040_0044, 1, 32'h0040_0800, 1, 0);
        cycle(32'h0040_0044, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("postResetHit", {31'd0, pred_hit}, 32'd1);
        chk("postResetTarget", pred_target, 32'h0040_0800);
        chk("postResetBranchCount", 32'(branch_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
